// File: rtl/fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// fb_write_arbiter
//   Shares the single framebuffer write port among NREQ drawing engines.
//   Round-robin arbitration; an owner keeps the grant for a whole primitive
//   (up to req_last), but yields after BURST pixels if someone else waits.
//   One arbitration cycle per grant change, then one pixel per cycle.
//   Write data is registered: fb_* appear one cycle after the transfer.
//
//   Optional build macro FB_ARB_CLIP_EN: off-screen pixels are still
//   accepted from the requester but never raise fb_we.
//
//   Ports
//     clk_sys, rst_sys    clock, asynchronous active-high reset
//     req_valid/last      per-requester handshake and end-of-primitive
//     req_x/y/cidx        packed per-requester pixel fields
//     req_ready           accept strobe back to the current owner
//     fb_busy             framebuffer is reading for display, stall writes
//     fb_we/x/y/cidx      registered framebuffer write port
//     grant               one-hot current owner, 0 when none
//     idle                no owner and no request pending
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   ARB   | no owner; pick next valid requester after the pointer
//   OWN   | requester ptr_q owns the port; accept pixels unless busy
// ---------------------------------------------------------------------------
module fb_write_arbiter #(
   parameter int CORDW  = 16,
   parameter int CIDXW  = 4,
   parameter int NREQ   = 4,
   parameter int BURST  = 16,
   parameter int WIDTH  = 320,
   parameter int HEIGHT = 180
) (
   input  logic                    clk_sys,
   input  logic                    rst_sys,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_last,
   input  logic [NREQ*CORDW-1:0]   req_x,
   input  logic [NREQ*CORDW-1:0]   req_y,
   input  logic [NREQ*CIDXW-1:0]   req_cidx,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fb_busy,
   output logic                    fb_we,
   output logic [CORDW-1:0]        fb_x,
   output logic [CORDW-1:0]        fb_y,
   output logic [CIDXW-1:0]        fb_cidx,
   output logic [NREQ-1:0]         grant,
   output logic                    idle
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BURST + 1);
   localparam logic [IW-1:0]    PTR_RST = IW'(NREQ - 1);
   localparam logic [CW-1:0]    BURST_C = CW'(BURST);
   localparam logic [CORDW-1:0] W_C     = CORDW'(WIDTH);
   localparam logic [CORDW-1:0] H_C     = CORDW'(HEIGHT);

`ifdef FB_ARB_CLIP_EN
   localparam bit CLIP_EN = 1'b1;
`else
   localparam bit CLIP_EN = 1'b0;
`endif

   typedef enum logic {ARB, OWN} state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [CW-1:0]     burst_q, burst_d;
   logic              fb_we_q, fb_we_d;
   logic [CORDW-1:0]  fb_x_q, fb_x_d;
   logic [CORDW-1:0]  fb_y_q, fb_y_d;
   logic [CIDXW-1:0]  fb_cidx_q, fb_cidx_d;

   logic              own_valid, own_last;
   logic [CORDW-1:0]  own_x, own_y;
   logic [CIDXW-1:0]  own_cidx;
   logic              found;
   logic [IW-1:0]     sel;
   logic              others;
   logic              in_bounds;
   logic              xfer;
   logic [CW-1:0]     burst_inc;

   // Fields of the requester the pointer names (the owner while in OWN).
   always_comb begin
      own_valid = 1'b0;
      own_last  = 1'b0;
      own_x     = '0;
      own_y     = '0;
      own_cidx  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (ptr_q == IW'(i)) begin
            own_valid = req_valid[i];
            own_last  = req_last[i];
            own_x     = req_x[i*CORDW +: CORDW];
            own_y     = req_y[i*CORDW +: CORDW];
            own_cidx  = req_cidx[i*CIDXW +: CIDXW];
         end
      end
   end

   // Round-robin search starting just after the last owner; k=NREQ wraps
   // back to the last owner itself so a lone requester can win again.
   always_comb begin
      found = 1'b0;
      sel   = ptr_q;
      for (int k = 1; k <= NREQ; k++) begin
         int idx;
         idx = (int'(ptr_q) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            sel   = IW'(idx);
         end
      end
   end

   assign others    = |(req_valid & ~grant_q);
   assign burst_inc = burst_q + CW'(1);

   // Coordinates are signed: a set sign bit means off-screen, after which
   // the unsigned compare against the extent is safe.
   assign in_bounds = !own_x[CORDW-1] && !own_y[CORDW-1] &&
                      (own_x < W_C) && (own_y < H_C);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      burst_d   = burst_q;
      fb_we_d   = 1'b0;
      fb_x_d    = fb_x_q;
      fb_y_d    = fb_y_q;
      fb_cidx_d = fb_cidx_q;
      req_ready = '0;
      xfer      = 1'b0;
      case (state_q)
         ARB: begin
            if (found) begin
               grant_d      = '0;
               grant_d[sel] = 1'b1;
               ptr_d        = sel;
               burst_d      = '0;
               state_d      = OWN;
            end
         end
         OWN: begin
            req_ready = grant_q & {NREQ{!fb_busy}};
            xfer      = own_valid && !fb_busy;
            if (xfer) begin
               fb_we_d   = in_bounds || !CLIP_EN;
               fb_x_d    = own_x;
               fb_y_d    = own_y;
               fb_cidx_d = own_cidx;
               if (own_last || (burst_inc == BURST_C && others)) begin
                  state_d = ARB;
                  grant_d = '0;
                  burst_d = '0;
               end else if (burst_inc == BURST_C) begin
                  // Nobody else waiting: start a fresh burst, keep the grant.
                  burst_d = '0;
               end else begin
                  burst_d = burst_inc;
               end
            end
         end
         default: begin
            state_d = ARB;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst_sys) begin
      if (rst_sys) begin
         state_q   <= ARB;
         ptr_q     <= PTR_RST;
         grant_q   <= '0;
         burst_q   <= '0;
         fb_we_q   <= 1'b0;
         fb_x_q    <= '0;
         fb_y_q    <= '0;
         fb_cidx_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_q   <= grant_d;
         burst_q   <= burst_d;
         fb_we_q   <= fb_we_d;
         fb_x_q    <= fb_x_d;
         fb_y_q    <= fb_y_d;
         fb_cidx_q <= fb_cidx_d;
      end
   end

   assign fb_we   = fb_we_q;
   assign fb_x    = fb_x_q;
   assign fb_y    = fb_y_q;
   assign fb_cidx = fb_cidx_q;
   assign grant   = grant_q;
   assign idle    = (state_q == ARB) && !(|req_valid);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_write_arbiter
//   Directed bench for fb_write_arbiter (default parameters). Each requester
//   is a small model that walks through numbered pixels and advances on
//   valid&ready. Expected framebuffer writes are queued in the order the
//   arbitration rules dictate and popped on every fb_we pulse.
// ---------------------------------------------------------------------------
module tb_fb_write_arbiter;

   localparam int NREQ = 4;
   localparam int CORDW = 16;
   localparam int CIDXW = 4;
   localparam int PW = 2*CORDW + CIDXW;

`ifdef FB_ARB_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   logic                    clk_sys = 1'b0;
   logic                    rst_sys;
   logic [NREQ-1:0]         req_valid, req_last, req_ready, grant;
   logic [NREQ*CORDW-1:0]   req_x, req_y;
   logic [NREQ*CIDXW-1:0]   req_cidx;
   logic                    fb_busy, fb_we, idle;
   logic [CORDW-1:0]        fb_x, fb_y;
   logic [CIDXW-1:0]        fb_cidx;

   fb_write_arbiter dut (
      .clk_sys(clk_sys), .rst_sys(rst_sys),
      .req_valid(req_valid), .req_last(req_last),
      .req_x(req_x), .req_y(req_y), .req_cidx(req_cidx),
      .req_ready(req_ready), .fb_busy(fb_busy),
      .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_cidx(fb_cidx),
      .grant(grant), .idle(idle)
   );

   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad   = 0;

   int rem [NREQ];
   int cnt [NREQ];
   bit last_en [NREQ];
   int bx [NREQ];
   int by [NREQ];
   int bc [NREQ];
   bit clip_mode = 1'b0;
   int clip_x [3] = '{319, 320, -1};
   logic [PW-1:0] exp_q [$];

   function automatic logic [PW-1:0] pix(input int i, input int n);
      logic [CORDW-1:0] x, y;
      logic [CIDXW-1:0] c;
      if (i == 0 && clip_mode) begin
         x = (n < 3) ? CORDW'(clip_x[n]) : '0;
         y = CORDW'(10);
         c = CIDXW'(1);
      end else begin
         x = CORDW'(bx[i] + n);
         y = CORDW'(by[i] + n);
         c = CIDXW'(bc[i] + n);
      end
      return {x, y, c};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i] = rem[i] > 0;
         req_last[i]  = last_en[i] && rem[i] == 1;
         {req_x[i*CORDW +: CORDW], req_y[i*CORDW +: CORDW],
          req_cidx[i*CIDXW +: CIDXW]} = pix(i, cnt[i]);
      end
   endtask

   task automatic push(input int i, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(pix(i, cnt[i] + k));
   endtask

   // One clock: sample the handshake mid-cycle, let the edge pass, advance
   // the requester models, then check any framebuffer write just produced.
   task automatic tick();
      logic [NREQ-1:0] fire;
      @(negedge clk_sys);
      fire = req_valid & req_ready;
      @(posedge clk_sys);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (fire[i]) begin
            cnt[i]++;
            rem[i]--;
         end
      end
      drive();
      if (fb_we === 1'b1) begin
         check("we_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) check("pixel", 64'({fb_x, fb_y, fb_cidx}), 64'(exp_q.pop_front()));
      end
   endtask

   task automatic run_until_idle(input string tag, input int max_cyc);
      int n = 0;
      while (!(idle === 1'b1 && fb_we === 1'b0 && exp_q.size() == 0) && n < max_cyc) begin
         tick();
         n++;
      end
      check(tag, 64'(n < max_cyc), 64'd1);
   endtask

   task automatic do_reset();
      rst_sys = 1'b1;
      tick();
      tick();
      rst_sys = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         rem[i] = 0; cnt[i] = 0; last_en[i] = 1'b0;
         bx[i] = i * 1000; by[i] = i * 100 + 3; bc[i] = i;
      end
      req_valid = '0; req_last = '0; req_x = '0; req_y = '0; req_cidx = '0;
      fb_busy = 1'b0;
      drive();
      do_reset();
      #1;
      check("rst_idle", 64'(idle), 64'd1);
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_we", 64'(fb_we), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);

      // Single pixel from requester 2
      bx[2] = 5; by[2] = 7; bc[2] = 3;
      rem[2] = 1; last_en[2] = 1'b1;
      push(2, 1);
      drive();
      tick();
      check("t1_grant", 64'(grant), 64'h4);
      check("t1_we_arb", 64'(fb_we), 64'd0);
      tick();
      check("t1_we", 64'(fb_we), 64'd1);
      check("t1_pix", 64'({fb_x, fb_y, fb_cidx}), 64'({16'd5, 16'd7, 4'd3}));
      check("t1_rel", 64'(grant), 64'd0);
      tick();
      check("t1_idle", 64'(idle), 64'd1);
      bx[2] = 2000;

      // Fairness with everyone valid and no req_last
      do_reset();
      for (int o = 0; o < 5; o++) push(o % NREQ, 0);
      begin
         int pc [NREQ];
         for (int i = 0; i < NREQ; i++) pc[i] = cnt[i];
         for (int o = 0; o < 5; o++) begin
            for (int k = 0; k < 16; k++) exp_q.push_back(pix(o % NREQ, pc[o % NREQ] + k));
            pc[o % NREQ] += 16;
         end
      end
      for (int i = 0; i < NREQ; i++) begin rem[i] = 1000; last_en[i] = 1'b0; end
      drive();
      for (int o = 0; o < 5; o++) begin
         tick();
         check("fair_grant", 64'(grant), 64'(1 << (o % NREQ)));
         check("fair_gap", 64'(fb_we), 64'd0);
         for (int b = 0; b < 16; b++) begin
            tick();
            check("fair_we", 64'(fb_we), 64'd1);
         end
         check("fair_rel", 64'(grant), 64'd0);
      end
      for (int i = 0; i < NREQ; i++) rem[i] = 0;
      drive();
      tick();
      check("fair_idle", 64'(idle), 64'd1);
      check("fair_drain", 64'(exp_q.size()), 64'd0);

      // fb_busy stall while requester 1 owns
      rem[1] = 10; last_en[1] = 1'b1;
      push(1, 10);
      drive();
      tick();
      check("busy_grant", 64'(grant), 64'h2);
      for (int b = 0; b < 3; b++) tick();
      fb_busy = 1'b1;
      #1;
      check("busy_ready0", 64'(req_ready), 64'd0);
      for (int b = 0; b < 5; b++) begin
         tick();
         check("busy_we", 64'(fb_we), 64'd0);
         check("busy_hold", 64'(grant), 64'h2);
         check("busy_ready", 64'(req_ready), 64'd0);
      end
      fb_busy = 1'b0;
      #1;
      check("busy_resume_rdy", 64'(req_ready), 64'h2);
      tick();
      check("busy_resume_we", 64'(fb_we), 64'd1);
      run_until_idle("busy_done", 50);

      // Lone requester 3, 40-pixel primitive
      rem[3] = 40; last_en[3] = 1'b1;
      push(3, 40);
      drive();
      tick();
      check("long_grant", 64'(grant), 64'h8);
      for (int j = 1; j <= 40; j++) begin
         tick();
         check("long_we", 64'(fb_we), 64'd1);
         check("long_hold", 64'(grant), (j < 40) ? 64'h8 : 64'h0);
      end
      tick();
      check("long_end_we", 64'(fb_we), 64'd0);
      check("long_idle", 64'(idle), 64'd1);

      // Reset in the middle of a primitive from requester 0
      rem[0] = 10; last_en[0] = 1'b1;
      push(0, 10);
      drive();
      tick();
      for (int b = 0; b < 3; b++) tick();
      check("mid_we_before", 64'(fb_we), 64'd1);
      rst_sys = 1'b1;
      #1;
      check("mid_rst_we", 64'(fb_we), 64'd0);
      check("mid_rst_grant", 64'(grant), 64'd0);
      check("mid_rst_ready", 64'(req_ready), 64'd0);
      exp_q.delete();
      rem[0] = 0;
      drive();
      tick();
      rem[0] = 2; rem[2] = 1; last_en[2] = 1'b1;
      push(0, 2);
      push(2, 1);
      drive();
      rst_sys = 1'b0;
      tick();
      check("mid_regrant", 64'(grant), 64'h1);
      run_until_idle("mid_done", 50);

      // Edge-of-screen pixels: x = 319, 320, -1
      clip_mode = 1'b1;
      cnt[0] = 0; rem[0] = 3; last_en[0] = 1'b1;
      if (CLIP) push(0, 1);
      else push(0, 3);
      drive();
      tick();
      check("clip_grant", 64'(grant), 64'h1);
      tick();
      check("clip_we_319", 64'(fb_we), 64'd1);
      tick();
      check("clip_we_320", 64'(fb_we), 64'(!CLIP));
      tick();
      check("clip_we_m1", 64'(fb_we), 64'(!CLIP));
      check("clip_rel", 64'(grant), 64'd0);
      run_until_idle("clip_done", 20);
      check("final_drain", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
